// File: rtl/link_stack.sv
// link_stack: return-address stack beside the XM23 execute stage.
// Detects LD-from-trap-address returns and redirects the PC to the link.
module link_stack #(
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 8,
    parameter int                ENABLE_W  = 41,
    parameter int                LD_IDX    = 33,
    parameter int                BL_IDX    = 34,
    parameter logic [ADDR_W-1:0] TRAP_ADDR = 16'hFFFF,
    parameter int                REG_OUT   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ENABLE_W-1:0]        enable_i,
    input  logic [ADDR_W-1:0]          src_val_i,
    input  logic [ADDR_W-1:0]          ret_addr_i,
    input  logic [ADDR_W-1:0]          lr_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       link_back_o,
    output logic [ADDR_W-1:0]          target_o,
    output logic                       underflow_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  tp;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic              valid;
    logic              push;
    logic              ret;
    logic              empty;
    logic              full;
    logic              pop;
    logic              replace;

    logic              link_c;
    logic              under_c;
    logic [ADDR_W-1:0] target_c;

    // only the LD and BL enables matter here
    logic              unused_en;

    assign unused_en = ^enable_i;

    assign valid   = !stall_i && !flush_i;
    assign push    = valid && enable_i[BL_IDX];
    assign ret     = valid && enable_i[LD_IDX]
                     && (src_val_i == TRAP_ADDR);
    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL);
    assign top_idx = tp - PTR_W'(1);

    // a return against a non-empty stack either pops or, with a
    // simultaneous BL, overwrites the top entry in place
    assign pop     = ret && !empty && !push;
    assign replace = ret && !empty && push;
    assign wr_idx  = replace ? top_idx : tp;

    // redirect decision for the instruction currently in execute
    always_comb begin
        link_c   = 1'b0;
        under_c  = 1'b0;
        target_c = '0;
        if (ret) begin
            link_c   = 1'b1;
            under_c  = empty;
            target_c = empty ? lr_i : mem[top_idx];
        end
    end

    // entry storage; contents need no reset, validity lives in cnt
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem[wr_idx] <= ret_addr_i;
        end
    end

    // pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (replace) begin
            tp  <= tp;
            cnt <= cnt;
        end else if (push) begin
            tp <= tp + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop) begin
            tp  <= top_idx;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign overflow_o = ovf;
    assign count_o    = cnt;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic              link_q;
            logic              under_q;
            logic [ADDR_W-1:0] target_q;

            // one-cycle registered redirect pulse
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    link_q   <= 1'b0;
                    under_q  <= 1'b0;
                    target_q <= '0;
                end else begin
                    link_q   <= link_c;
                    under_q  <= under_c;
                    target_q <= target_c;
                end
            end

            assign link_back_o = link_q;
            assign underflow_o = under_q;
            assign target_o    = target_q;
        end else begin : g_comb
            assign link_back_o = link_c;
            assign underflow_o = under_c;
            assign target_o    = target_c;
        end
    endgenerate

endmodule
